// File: rtl/dev_uart_if.sv
// Bus lane between the hs32 MMIO interconnect and the UART peripheral.
// The interconnect drives the request side. The peripheral returns ack/dtr.
interface dev_uart_if;
   logic        stb;
   logic        ack;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] dtw;
   logic [31:0] dtr;

   modport master (output stb, we, addr, dtw, input ack, dtr);
   modport slave  (input stb, we, addr, dtw, output ack, dtr);
endinterface

// File: rtl/dev_uart.sv
// Memory-mapped 8N1 UART with RX/TX FIFOs, a programmable baud divisor and a
// level interrupt. Each bit lasts DIV+1 clk cycles.
module dev_uart #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_BITS   = 16,
   parameter int RESET_DIV  = 103
) (
   input  logic      clk,
   input  logic      rst,
   dev_uart_if.slave bus,
   input  logic      rx,
   output logic      tx,
   output logic      tx_oe,
   output logic      intrq
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [DIV_BITS-1:0] div_reg;
   logic                en, ie_rx, ie_tx, ie_err;
   logic                overrun, frame_err;

   logic [7:0] rx_mem [FIFO_DEPTH];
   logic [7:0] tx_mem [FIFO_DEPTH];
   logic [AW:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic        rx_empty, rx_full, tx_fifo_empty, tx_full, tx_empty_st;

   state_t              tx_state, rx_state;
   logic [DIV_BITS-1:0] tx_cnt, tx_div, rx_cnt, rx_div, rx_half;
   logic [DIV_BITS:0]   rx_div_p1;
   logic [2:0]          tx_bit, rx_bit;
   logic [7:0]          tx_shr, rx_shr;
   logic                rx_p0, rx_p1, rx_p2;

   logic        acc, wr, rd;
   logic        rx_pop, rx_push_req, rx_push, rx_ovr, rx_ferr, rx_smp;
   logic        tx_pop, tx_push, tx_bit_end;
   logic [31:0] rd_data;
   logic        unused_dtw;

   assign unused_dtw = ^bus.dtw;

   assign rx_empty      = (rx_wp == rx_rp);
   assign rx_full       = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign tx_fifo_empty = (tx_wp == tx_rp);
   assign tx_full       = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_empty_st   = tx_fifo_empty && (tx_state == S_IDLE);

   // Every side effect is keyed off acc, the cycle in which ack gets registered.
   assign acc = bus.stb & ~bus.ack;
   assign wr  = acc & bus.we;
   assign rd  = acc & ~bus.we;

   assign rx_pop  = rd && (bus.addr == 2'd0) && !rx_empty;
   assign tx_bit_end = (tx_cnt == tx_div);
   assign tx_pop  = en && !tx_fifo_empty &&
                    ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));
   assign tx_push = wr && (bus.addr == 2'd0) && (!tx_full || tx_pop);

   assign rx_div_p1   = {1'b0, rx_div} + (DIV_BITS+1)'(1);
   assign rx_half     = rx_div_p1[DIV_BITS:1];
   assign rx_smp      = (rx_state == S_START) ? (rx_cnt == rx_half) : (rx_cnt == rx_div);
   assign rx_push_req = en && (rx_state == S_STOP) && rx_smp && rx_p1;
   assign rx_ferr     = en && (rx_state == S_STOP) && rx_smp && !rx_p1;
   assign rx_push     = rx_push_req && (!rx_full || rx_pop);
   assign rx_ovr      = rx_push_req && rx_full && !rx_pop;

   assign tx_oe = en;

   always_comb begin
      rd_data = '0;
      case (bus.addr)
         2'd0: if (!rx_empty) rd_data[7:0] = rx_mem[rx_rp[AW-1:0]];
         2'd1: rd_data[5:0] = {frame_err, overrun, tx_full, tx_empty_st, rx_full, !rx_empty};
         2'd2: rd_data[DIV_BITS-1:0] = div_reg;
         default: rd_data[3:0] = {ie_err, ie_tx, ie_rx, en};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ack <= 1'b0;
         bus.dtr <= '0;
         intrq   <= 1'b0;
      end else begin
         bus.ack <= acc;
         bus.dtr <= rd ? rd_data : '0;
         intrq   <= (ie_rx & !rx_empty) | (ie_tx & tx_empty_st) | (ie_err & (overrun | frame_err));
      end
   end

   // Sticky error flags: a new event in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg   <= DIV_BITS'(RESET_DIV);
         {ie_err, ie_tx, ie_rx, en} <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (wr && bus.addr == 2'd2)
            div_reg <= (bus.dtw[DIV_BITS-1:0] < DIV_BITS'(3)) ? DIV_BITS'(3) : bus.dtw[DIV_BITS-1:0];
         if (wr && bus.addr == 2'd3)
            {ie_err, ie_tx, ie_rx, en} <= bus.dtw[3:0];
         if (wr && bus.addr == 2'd1) begin
            if (bus.dtw[4]) overrun   <= 1'b0;
            if (bus.dtw[5]) frame_err <= 1'b0;
         end
         if (rx_ovr)  overrun   <= 1'b1;
         if (rx_ferr) frame_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wp <= '0;
         rx_rp <= '0;
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shr;
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.dtw[7:0];
   end

   // TX: STOP chains straight into the next START when a byte is waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_div   <= DIV_BITS'(RESET_DIV);
         tx_bit   <= '0;
      end else if (!en) begin
         tx_state <= S_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               tx <= 1'b1;
               if (tx_pop) begin
                  tx_shr   <= tx_mem[tx_rp[AW-1:0]];
                  tx       <= 1'b0;
                  tx_state <= S_START;
                  tx_cnt   <= '0;
                  tx_div   <= div_reg;
               end
            end
            S_START: begin
               if (tx_bit_end) begin
                  tx       <= tx_shr[0];
                  tx_shr   <= tx_shr >> 1;
                  tx_bit   <= '0;
                  tx_state <= S_DATA;
                  tx_cnt   <= '0;
                  tx_div   <= div_reg;
               end else tx_cnt <= tx_cnt + DIV_BITS'(1);
            end
            S_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  tx_div <= div_reg;
                  if (tx_bit == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     tx     <= tx_shr[0];
                     tx_shr <= tx_shr >> 1;
                     tx_bit <= tx_bit + 3'd1;
                  end
               end else tx_cnt <= tx_cnt + DIV_BITS'(1);
            end
            default: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  tx_div <= div_reg;
                  if (tx_pop) begin
                     tx_shr   <= tx_mem[tx_rp[AW-1:0]];
                     tx       <= 1'b0;
                     tx_state <= S_START;
                  end else tx_state <= S_IDLE;
               end else tx_cnt <= tx_cnt + DIV_BITS'(1);
            end
         endcase
      end
   end

   // RX: two-flop synchroniser (rx_p0, rx_p1), rx_p2 holds the previous synced level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_p0    <= 1'b1;
         rx_p1    <= 1'b1;
         rx_p2    <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DIV_BITS'(RESET_DIV);
         rx_bit   <= '0;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
         if (!en) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
         end else begin
            case (rx_state)
               S_IDLE: begin
                  if (rx_p2 && !rx_p1) begin
                     rx_state <= S_START;
                     rx_cnt   <= '0;
                     rx_div   <= div_reg;
                  end
               end
               S_START: begin
                  if (rx_smp) begin
                     rx_cnt <= '0;
                     rx_div <= div_reg;
                     rx_bit <= '0;
                     rx_state <= rx_p1 ? S_IDLE : S_DATA;
                  end else rx_cnt <= rx_cnt + DIV_BITS'(1);
               end
               S_DATA: begin
                  if (rx_smp) begin
                     rx_shr <= {rx_p1, rx_shr[7:1]};
                     rx_cnt <= '0;
                     rx_div <= div_reg;
                     if (rx_bit == 3'd7) rx_state <= S_STOP;
                     else rx_bit <= rx_bit + 3'd1;
                  end else rx_cnt <= rx_cnt + DIV_BITS'(1);
               end
               default: begin
                  if (rx_smp) rx_state <= S_IDLE;
                  else rx_cnt <= rx_cnt + DIV_BITS'(1);
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dev_uart.sv
// Directed bench for dev_uart: register reset values, TX waveform, loopback,
// RX FIFO overrun, frame error, glitch rejection and TX FIFO overflow.
module tb_dev_uart;
   logic clk = 1'b0;
   logic rst;
   logic rx, rx_drv, loop, tx, tx_oe, intrq;
   int   errors = 0;
   int   checks = 0;

   logic       mon_en = 1'b0;
   int         frames = 0;
   logic [7:0] mon_q[$];

   dev_uart_if bus();

   always #5 clk = ~clk;
   assign rx = loop ? tx : rx_drv;

   dev_uart #(.FIFO_DEPTH(4), .DIV_BITS(16), .RESET_DIV(103)) dut (
      .clk(clk), .rst(rst), .bus(bus), .rx(rx), .tx(tx), .tx_oe(tx_oe), .intrq(intrq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] q);
      int n;
      @(posedge clk); #1;
      bus.stb = 1'b1; bus.we = w; bus.addr = a; bus.dtw = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.ack && n < 8);
      check("ack", {31'b0, bus.ack}, 32'd1);
      q = bus.dtr;
      bus.stb = 1'b0; bus.we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] q;
      xfer(1'b1, a, d, q);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      logic [31:0] q;
      xfer(1'b0, a, 32'd0, q);
      check(tag, q & mask, exp);
   endtask

   task automatic drive_bit(input logic v);
      rx_drv = v;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      rx_drv = 1'b1;
   endtask

   // Frame decoder on tx for a 10-cycle bit period.
   initial begin
      logic [7:0] mb;
      logic       ms;
      forever begin
         @(posedge clk); #1;
         if (mon_en && tx === 1'b0) begin
            repeat (15) @(posedge clk); #1;
            mb[0] = tx;
            for (int i = 1; i < 8; i++) begin
               repeat (10) @(posedge clk); #1;
               mb[i] = tx;
            end
            repeat (10) @(posedge clk); #1;
            ms = tx;
            if (ms === 1'b1) begin
               frames++;
               mon_q.push_back(mb);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] fr;
      int         bad, n;

      rst = 1'b1; rx_drv = 1'b1; loop = 1'b0;
      bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.dtw = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_ack", {31'b0, bus.ack}, 32'd0);
      check("rst_dtr", bus.dtr, 32'd0);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_tx_oe", {31'b0, tx_oe}, 32'd0);
      check("rst_intrq", {31'b0, intrq}, 32'd0);
      rd_chk("rst_div", 2'd2, 32'hFFFF_FFFF, 32'd103);
      @(posedge clk); #1;
      check("dtr_idle", bus.dtr, 32'd0);
      rd_chk("rst_ctrl", 2'd3, 32'hFFFF_FFFF, 32'd0);
      rd_chk("rst_status", 2'd1, 32'hFFFF_FFFF, 32'h04);

      // DIV clamps to 3, then a 0xA5 frame with 4-cycle bits
      wr(2'd2, 32'd1);
      rd_chk("div_clamp", 2'd2, 32'hFFFF_FFFF, 32'd3);
      wr(2'd3, 32'h1);
      check("tx_oe_en", {31'b0, tx_oe}, 32'd1);
      wr(2'd0, 32'hA5);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (tx !== 1'b0 && n < 50);
      check("tx_start_seen", {31'b0, tx}, 32'd0);
      fr = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int c = 0; c < 4; c++) begin
            if (k != 0 || c != 0) begin
               @(posedge clk); #1;
            end
            if (tx !== fr[k]) bad++;
         end
         check($sformatf("tx_bit%0d", k), bad, 32'd0);
      end
      rd_chk("tx_done_status", 2'd1, 32'hFFFF_FFFF, 32'h04);

      // Loopback 0x3C at DIV=9 with RX interrupt enabled
      loop = 1'b1;
      wr(2'd2, 32'd9);
      wr(2'd3, 32'h3);
      wr(2'd0, 32'h3C);
      check("intrq_before", {31'b0, intrq}, 32'd0);
      n = 0;
      while (intrq !== 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("intrq_rise", {31'b0, intrq}, 32'd1);
      check("intrq_after_frame", {31'b0, (n > 80)}, 32'd1);
      rd_chk("loop_data", 2'd0, 32'hFFFF_FFFF, 32'h3C);
      @(posedge clk); #1;
      check("intrq_fall", {31'b0, intrq}, 32'd0);
      rd_chk("loop_empty_read", 2'd0, 32'hFFFF_FFFF, 32'h0);
      repeat (20) @(posedge clk);
      #1 loop = 1'b0;
      wr(2'd3, 32'h1);

      // Five bytes into a four-entry RX FIFO
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      repeat (20) @(posedge clk);
      rd_chk("rx_full_ovr", 2'd1, 32'h33, 32'h13);
      for (int i = 1; i <= 4; i++) rd_chk($sformatf("rx_byte%0d", i), 2'd0, 32'hFFFF_FFFF, i);
      wr(2'd1, 32'h10);
      rd_chk("ovr_cleared", 2'd1, 32'h33, 32'h00);

      // Stop bit low, then a one-cycle glitch
      send_byte(8'h55, 1'b0);
      repeat (20) @(posedge clk);
      rd_chk("frame_err", 2'd1, 32'h33, 32'h20);
      wr(2'd1, 32'h20);
      rd_chk("ferr_cleared", 2'd1, 32'h33, 32'h00);
      @(posedge clk); #1;
      rx_drv = 1'b0;
      @(posedge clk); #1;
      rx_drv = 1'b1;
      repeat (40) @(posedge clk);
      rd_chk("glitch_ignored", 2'd1, 32'h33, 32'h00);

      // Six writes: one in the shifter, four queued, one dropped
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) wr(2'd0, 32'h11 + i);
      rd_chk("tx_full", 2'd1, 32'h0C, 32'h08);
      repeat (700) @(posedge clk);
      #1;
      check("tx_frames", frames, 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < mon_q.size()) check($sformatf("tx_byte%0d", i), {24'b0, mon_q[i]}, 32'h11 + i);
         else check($sformatf("tx_byte%0d_missing", i), 32'd0, 32'h11 + i);
      end
      rd_chk("tx_drained", 2'd1, 32'h0C, 32'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
